// File: rtl/shifter_normalizer_pkg.sv
// Shared definitions for the shifter normalizer.
//   WIDTH      : data width (16; stage sizes 8/4/2/1 derive from it)
//   SHAMT_W    : shift-amount width, log2(WIDTH)
//   state_t    : control FSM states
//   stage_size : shift size used by binary-search stage k (WIDTH/2 >> k)
package shifter_pkg;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE
    } state_t;

    function automatic logic [SHAMT_W-1:0] stage_size(input logic [1:0] k);
        return SHAMT_W'(WIDTH / 2) >> k;
    endfunction

endpackage

// File: rtl/shifter_normalizer_if.sv
// Request/response bus of the shifter normalizer.
//   in_valid/in_ready/in_data/in_left       : request handshake
//   out_valid/out_ready/out_data/out_shamt/
//   out_zero                                : result handshake
// master: the requester/consumer side; slave: the normalizer itself.
interface shifter_normalizer_if;
    import shifter_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               in_left;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SHAMT_W-1:0] out_shamt;
    logic               out_zero;

    modport master (
        output in_valid, in_data, in_left, out_ready,
        input  in_ready, out_valid, out_data, out_shamt, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_left, out_ready,
        output in_ready, out_valid, out_data, out_shamt, out_zero
    );

endinterface

// File: rtl/shifter_normalizer_step.sv
// One combinational binary-search stage of the normalizer.
//   work      : current working word
//   size      : stage shift size (8, 4, 2 or 1)
//   left      : 1 = test/shift the top bits left, 0 = bottom bits right
//   next_work : word after this stage (shifted only on a hit)
//   hit       : the tested size-bit field was all zeros
module shifter_norm_step
    import shifter_pkg::*;
(
    input  logic [WIDTH-1:0]   work,
    input  logic [SHAMT_W-1:0] size,
    input  logic               left,
    output logic [WIDTH-1:0]   next_work,
    output logic               hit
);

    logic [WIDTH-1:0] low_mask;

    always_comb begin
        low_mask  = (WIDTH'(1) << size) - WIDTH'(1);
        next_work = work;
        if (left) begin
            // top 'size' bits are zero when nothing survives shifting them down
            hit = (work >> (WIDTH - int'(size))) == '0;
        end else begin
            hit = (work & low_mask) == '0;
        end
        if (hit) begin
            next_work = left ? (work << size) : (work >> size);
        end
    end

endmodule

// File: rtl/shifter_normalizer.sv
// Iterative leading/trailing-zero normalizer, one binary-search stage
// (8, 4, 2, 1) per cycle.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : shifter_normalizer_if.slave request/result handshakes
// Optional macro SHIFTER_NORM_EARLY_EXIT_EN: zero or already-normalized
// inputs skip the stage cycles and go straight to DONE.
module shifter_normalizer
    import shifter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    shifter_normalizer_if.slave  bus
);

    state_t             state, next_state;
    logic [1:0]         cnt;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   step_work;
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W-1:0] size;
    logic               left;
    logic               zero;
    logic               hit;
    logic               accept;
    logic               early;

    assign size   = stage_size(cnt);
    assign accept = bus.in_valid && (state == IDLE);

`ifdef SHIFTER_NORM_EARLY_EXIT_EN
    assign early = (bus.in_data == '0) ||
                   (bus.in_left ? bus.in_data[WIDTH-1] : bus.in_data[0]);
`else
    assign early = 1'b0;
`endif

    shifter_norm_step u_step (
        .work      (work),
        .size      (size),
        .left      (left),
        .next_work (step_work),
        .hit       (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = early ? DONE : STEP;
            STEP:    if (cnt == 2'd3) next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work  <= '0;
            shamt <= '0;
            left  <= 1'b0;
            zero  <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            work  <= bus.in_data;
            left  <= bus.in_left;
            zero  <= (bus.in_data == '0);
            cnt   <= '0;
            // an early-exited zero word must report the same all-ones shift
            // the full four-stage run would accumulate
            shamt <= (early && (bus.in_data == '0)) ? '1 : '0;
        end else if (state == STEP) begin
            work <= step_work;
            if (hit) shamt <= shamt | size;
            cnt <= cnt + 2'd1;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = work;
    assign bus.out_shamt = shamt;
    assign bus.out_zero  = zero;

endmodule

// File: tb/tb_shifter_normalizer.sv
// Self-checking bench for shifter_normalizer: directed cases, backpressure,
// mid-operation reset and random vectors checked against a scoreboard.
module tb_shifter_normalizer;
    import shifter_pkg::*;

    typedef struct {
        logic [15:0] din;
        logic        left;
        logic [15:0] data;
        logic [3:0]  shamt;
        logic        zero;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    shifter_normalizer_if bus ();

    shifter_normalizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: count leading/trailing zeros bit by bit.
    function automatic exp_t model(input logic [15:0] d, input logic l);
        exp_t e;
        int   n;
        e.din  = d;
        e.left = l;
        e.zero = (d == 16'h0);
        n = 0;
        if (d == 16'h0) begin
            n = 15;
        end else if (l) begin
            while (d[15 - n] == 1'b0) n++;
        end else begin
            while (d[n] == 1'b0) n++;
        end
        e.shamt = 4'(n);
        e.data  = (d == 16'h0) ? 16'h0 : (l ? (d << n) : (d >> n));
        return e;
    endfunction

    function automatic int exp_latency(input logic [15:0] d, input logic l);
`ifdef SHIFTER_NORM_EARLY_EXIT_EN
        if (d == 16'h0 || (l ? d[15] : d[0])) return 1;
`endif
        return 4;
    endfunction

    // Wait up to a bounded number of edges for out_valid; returns edges waited.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < 20);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"},  32'(bus.out_data),  32'(e.data));
        chk({tag, "_shamt"}, 32'(bus.out_shamt), 32'(e.shamt));
        chk({tag, "_zero"},  32'(bus.out_zero),  32'(e.zero));
        if (e.din != 16'h0) begin
            chk({tag, "_norm_bit"},
                32'(e.left ? bus.out_data[15] : bus.out_data[0]), 32'd1);
        end
        chk({tag, "_inverse"},
            32'(e.left ? (bus.out_data >> bus.out_shamt) : (bus.out_data << bus.out_shamt)),
            32'(e.din));
    endtask

    // Full transaction: request, latency check, result check, output handshake.
    task automatic run_txn(input string tag, input logic [15:0] d, input logic l);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_left  = l;
        sb.push_back(model(d, l));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        wait_result(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_latency(d, l)));
        check_result(tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_out_valid_low"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [15:0] hold_data;
        logic [3:0]  hold_shamt;
        logic [15:0] d;

        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_left   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_shamt", 32'(bus.out_shamt), 32'd0);
        chk("rst_out_zero",  32'(bus.out_zero),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with spec-given expected values
        run_txn("clz_0010", 16'h0010, 1'b1);
        run_txn("ctz_00a0", 16'h00A0, 1'b0);
        run_txn("norm_8000", 16'h8000, 1'b1);
        run_txn("zero_left", 16'h0000, 1'b1);
        run_txn("zero_right", 16'h0000, 1'b0);
        run_txn("norm_0001_r", 16'h0001, 1'b0);
        run_txn("ctz_8000", 16'h8000, 1'b0);

        // Backpressure: hold out_ready low with a second request pending
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0010;
        bus.in_left  = 1'b1;
        sb.push_back(model(16'h0010, 1'b1));
        @(posedge clk); #1;
        bus.in_data = 16'h0001;
        bus.in_left = 1'b1;
        wait_result(lat);
        chk("bp_latency", 32'(lat), 32'(exp_latency(16'h0010, 1'b1)));
        hold_data  = bus.out_data;
        hold_shamt = bus.out_shamt;
        check_result("bp_first");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_data",  32'(bus.out_data),  32'(hold_data));
            chk("bp_hold_shamt", 32'(bus.out_shamt), 32'(hold_shamt));
            chk("bp_hold_ready", 32'(bus.in_ready),  32'd0);
        end
        sb.push_back(model(16'h0001, 1'b1));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_hs_valid_low", 32'(bus.out_valid), 32'd0);
        chk("bp_hs_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_second_accepted", 32'(bus.in_ready), 32'd0);
        wait_result(lat);
        chk("bp2_latency", 32'(lat), 32'(exp_latency(16'h0001, 1'b1)));
        check_result("bp_second");
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset asserted during stage 2 drops the in-flight request
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        bus.in_left  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("midrst_out_data",  32'(bus.out_data),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_txn("after_rst_0300", 16'h0300, 1'b1);

        // Random vectors, both modes, with varied leading/trailing zeros
        for (int i = 0; i < 10000; i++) begin
            d = 16'($urandom);
            case ($urandom_range(0, 3))
                0: d = d >> $urandom_range(0, 15);
                1: d = d << $urandom_range(0, 15);
                2: if ($urandom_range(0, 15) == 0) d = 16'h0;
                default: ;
            endcase
            run_txn("rand", d, 1'($urandom_range(0, 1)));
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
